// File: rtl/alu_mc.sv
// Multi-cycle accumulator ALU: single-cycle ops plus an optional WIDTH-cycle
// shift-add multiplier, built only when ALU_MUL_EN is defined.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             busy,
  output logic             done
);

  localparam int M = WIDTH - 1;
  localparam logic [2:0] OP_PASS = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                         OP_OR   = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;

  logic [WIDTH-1:0] dout_q, dhi_q;
  logic             z_q, c_q, n_q, v_q, done_q;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_d;
  logic             c_d, v_d;
  logic             idle, single_go;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     part;

  // Low half starts as B and shifts out one multiplier bit per cycle while
  // the product grows in from the top.
  assign part   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign prod_d = {part, prod_q[WIDTH-1:1]};
  assign idle   = (state_q == IDLE);
  assign busy   = (state_q == MUL_RUN);
`else
  assign idle = 1'b1;
  assign busy = 1'b0;
`endif

  assign single_go = start && idle && (control != OP_MUL);

  always_comb begin
    sum   = {1'b0, ac_in} + {1'b0, bus_in};
    diff  = {1'b0, ac_in} - {1'b0, bus_in};
    res_d = bus_in;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (control)
      OP_PASS: res_d = bus_in;
      OP_ADD: begin
        res_d = sum[M:0];
        c_d   = sum[WIDTH];
        v_d   = (ac_in[M] == bus_in[M]) && (sum[M] != ac_in[M]);
      end
      OP_SUB: begin
        res_d = diff[M:0];
        c_d   = diff[WIDTH];
        v_d   = (ac_in[M] != bus_in[M]) && (diff[M] != ac_in[M]);
      end
      OP_AND: res_d = ac_in & bus_in;
      OP_OR:  res_d = ac_in | bus_in;
      OP_SHL: begin
        res_d = {ac_in[M-1:0], 1'b0};
        c_d   = ac_in[M];
      end
      OP_SHR: begin
        res_d = {1'b0, ac_in[M:1]};
        c_d   = ac_in[0];
      end
      default: res_d = bus_in;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      dhi_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_MUL_EN
      state_q <= IDLE;
      a_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (single_go) begin
        dout_q <= res_d;
        dhi_q  <= '0;
        z_q    <= (res_d == '0);
        n_q    <= res_d[M];
        c_q    <= c_d;
        v_q    <= v_d;
        done_q <= 1'b1;
      end
`ifdef ALU_MUL_EN
      if (idle && start && (control == OP_MUL)) begin
        a_q     <= ac_in;
        prod_q  <= {{WIDTH{1'b0}}, bus_in};
        cnt_q   <= '0;
        state_q <= MUL_RUN;
      end
      if (state_q == MUL_RUN) begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          dout_q  <= prod_d[WIDTH-1:0];
          dhi_q   <= prod_d[2*WIDTH-1:WIDTH];
          z_q     <= (prod_d == '0);
          n_q     <= prod_d[2*WIDTH-1];
          c_q     <= (prod_d[2*WIDTH-1:WIDTH] != '0);
          v_q     <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
      end
`else
      // Without the multiplier, opcode 7 only acknowledges.
      if (start && (control == OP_MUL)) done_q <= 1'b1;
`endif
    end
  end

  assign data_out = dout_q;
  assign data_hi  = dhi_q;
  assign flag_z   = z_q;
  assign flag_c   = c_q;
  assign flag_n   = n_q;
  assign flag_v   = v_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=16); expected results are queued at
// issue time and popped whenever done is seen.
module tb_alu_mc;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] dout;
    logic [W-1:0] dhi;
    logic         z, c, n, v;
  } res_t;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   control = 3'd0;
  logic [W-1:0] ac_in = '0, bus_in = '0;
  logic [W-1:0] data_out, data_hi;
  logic         flag_z, flag_c, flag_n, flag_v, busy, done;

  int    checks = 0, failures = 0;
  res_t  exq[$];
  string tagq[$];
  res_t  last = '0;
  res_t  mon_e;
  string mon_t;

  alu_mc #(.WIDTH(W)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .control(control),
    .ac_in(ac_in), .bus_in(bus_in), .data_out(data_out), .data_hi(data_hi),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input res_t prev);
    res_t        r;
    int unsigned s;
    int          sa, sb, sr;
    logic [31:0] p;
    r  = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      0: r.dout = b;
      1: begin
        s = a + b; r.dout = s[W-1:0]; r.c = (s > 32'hFFFF);
        sr = sa + sb; r.v = (sr > 32767) || (sr < -32768);
      end
      2: begin
        r.dout = a - b; r.c = (a < b);
        sr = sa - sb; r.v = (sr > 32767) || (sr < -32768);
      end
      3: r.dout = a & b;
      4: r.dout = a | b;
      5: begin r.dout = W'(a * 2); r.c = (a >= 16'h8000); end
      6: begin r.dout = a / 2; r.c = (a % 2) != 0; end
      default: begin
`ifdef ALU_MUL_EN
        p = {16'h0, a} * {16'h0, b};
        r.dout = p[15:0]; r.dhi = p[31:16];
        r.z = (p == 0); r.n = p[31]; r.c = (p[31:16] != 0);
        return r;
`else
        return prev;
`endif
      end
    endcase
    r.z = (r.dout == 0);
    r.n = r.dout[W-1];
    return r;
  endfunction

  always @(negedge clock) begin
    if (rst_n && done === 1'b1) begin
      if (exq.size() == 0) chk("spurious_done", done, 1'b0);
      else begin
        mon_e = exq.pop_front();
        mon_t = tagq.pop_front();
        chk(mon_t, {data_out, data_hi, flag_z, flag_c, flag_n, flag_v}, mon_e);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    @(negedge clock);
    control = op; ac_in = a; bus_in = b; start = 1'b1;
    last = model(op, a, b, last);
    exq.push_back(last);
    tagq.push_back(tag);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exq.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_drain"}, exq.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {data_out, data_hi, flag_z, flag_c, flag_n, flag_v, busy, done}, '0);
  endtask

`ifdef ALU_MUL_EN
  // Issue a MUL, inject an ignored ADD and scramble operands mid-run,
  // then measure latency and busy coverage.
  task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int lat = 0;
    bit busy_ok = 1'b1;
    drive(3'd7, a, b, tag);
    ac_in = 16'hFFFF; bus_in = 16'hFFFF;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == 5) begin control = 3'd1; start = 1'b1; end
      if (lat == 6) start = 1'b0;
      @(negedge clock);
      lat++;
    end
    chk({tag, "_latency"}, lat, 16);
    chk({tag, "_busy_held"}, busy_ok, 1'b1);
    chk({tag, "_busy_clear"}, busy, 1'b0);
    drain(tag);
  endtask
`endif

  initial begin
    repeat (2) @(negedge clock);
    chk_zero("reset_init");
    rst_n = 1'b1;

    drive(3'd1, 16'h0001, 16'h0001, "add_pre");
    drain("add_pre");
    #3 rst_n = 1'b0;
    #1 chk_zero("reset_async");
    last = '0;
    @(negedge clock);
    rst_n = 1'b1;

    drive(3'd1, 16'hFFFF, 16'h0001, "add_wrap");
    drain("add_wrap");
    drive(3'd2, 16'h0002, 16'h0006, "sub_borrow");
    drain("sub_borrow");
    drive(3'd2, 16'h0005, 16'h0004, "sub_plain");
    drain("sub_plain");
    drive(3'd1, 16'h7FFF, 16'h0001, "add_ovf");
    drain("add_ovf");
    drive(3'd5, 16'h8001, 16'h1234, "shl");
    drain("shl");
    drive(3'd6, 16'h0003, 16'h5678, "shr");
    drain("shr");
    drive(3'd3, 16'hF0F0, 16'h0FF0, "and");
    drain("and");
    drive(3'd4, 16'hF000, 16'h000F, "or");
    drain("or");
    drive(3'd2, 16'h8000, 16'h0001, "sub_ovf");
    drain("sub_ovf");

    // Back-to-back single-cycle ops: done stays high two cycles.
    @(negedge clock);
    control = 3'd0; bus_in = 16'hA5A5; start = 1'b1;
    last = model(0, ac_in, 16'hA5A5, last); exq.push_back(last); tagq.push_back("b2b_pass");
    @(negedge clock);
    control = 3'd1; ac_in = 16'h1000; bus_in = 16'h0234;
    last = model(1, 16'h1000, 16'h0234, last); exq.push_back(last); tagq.push_back("b2b_add");
    @(negedge clock);
    start = 1'b0;
    drain("b2b");

`ifdef ALU_MUL_EN
    mul_run(16'h0123, 16'h0100, "mul_a");
    mul_run(16'h0000, 16'hFFFF, "mul_zero");
    mul_run(16'hFFFF, 16'hFFFF, "mul_max");

    // Reset partway through a MUL: abort with no completion.
    @(negedge clock);
    control = 3'd7; ac_in = 16'h1234; bus_in = 16'h5678; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    chk("mul_abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1 chk_zero("mul_abort_reset");
    last = '0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("mul_abort_no_done", done, 1'b0);
    drive(3'd1, 16'h0002, 16'h0003, "add_after_abort");
    drain("add_after_abort");
`else
    drive(3'd1, 16'h0001, 16'h0001, "add_1_1");
    drain("add_1_1");
    drive(3'd7, 16'h1234, 16'h5678, "op7_noop");
    chk("op7_busy", busy, 1'b0);
    drain("op7_noop");
    chk("op7_data_kept", data_out, 16'h0002);
`endif

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
